instr_fetch: RTL and testbench

- Instruction fetch stage that drives the synchronous-read instruction ROM and feeds the decoder.
- Owns the program counter and hides the ROM's 1-cycle read latency.
- Buffers fetched words in a 2-entry queue so the decoder can stall without losing data.
- Handles branch/jump redirects by flushing stale fetches.

---
 rtl/makina_fetch_pkg.sv | 16 +
 rtl/fetch_skid_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/makina_fetch_pkg.sv
// Shared widths, reset PC, ROM size and the queue entry type for the fetch stage.
package makina_fetch_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int ROM_DEPTH = 15001;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(ROM_DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry queue of fetched words; head is always slot 0, flush beats push.
module fetch_skid_fifo
    import makina_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = slot0;

    // Slot 0 is left untouched when the queue empties so the head outputs hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (do_push && do_pop) begin
            if (count == 2'd2) begin
                slot0 <= slot1;
                slot1 <= push_data;
            end else begin
                slot0 <= push_data;
            end
        end else if (do_push) begin
            if (count == 2'd0) begin
                slot0 <= push_data;
            end else begin
                slot1 <= push_data;
            end
            count <= count + 2'd1;
        end else if (do_pop) begin
            if (count == 2'd2) begin
                slot0 <= slot1;
            end
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, hides the 1-cycle ROM latency, buffers words for the decoder.
// Optional FETCH_COUNT_EN adds a 32-bit accepted-instruction counter port.
module instr_fetch
    import makina_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_instruction,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_fault
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    fetch_entry_t      head;
    fetch_entry_t      response;
    logic [1:0]        count;
    logic              pop;
    logic              push;
    logic [2:0]        occupancy;
    logic              can_request;
    logic              issue;
    logic              fault_hit;

    // Handshake: a word transfers on every rising edge where instr_valid && instr_ready;
    // while valid is high and ready is low, instr_out/instr_pc stay stable.
    assign pop         = instr_valid && instr_ready;
    assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign can_request = !halt && !redirect_valid && !fetch_fault && (occupancy < 3'd2);
    assign issue       = can_request && (fetch_pc <= LAST_PC);
    assign fault_hit   = can_request && (fetch_pc > LAST_PC);
    assign push        = inflight && !redirect_valid;
    assign response    = '{instr: rom_instruction, pc: inflight_pc};

    assign rom_address = fetch_pc;
    assign instr_valid = (count != 2'd0);
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Dropping inflight discards the stale ROM word returning next cycle.
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(1);
            end
            if (fault_hit) begin
                fetch_fault <= 1'b1;
            end
        end
    end

    fetch_skid_fifo u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (response),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven streaming/back-pressure plus redirect, fault, halt, reset sequences.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] rom_address;
    logic [15:0] rom_instruction;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        fetch_fault;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vec[14];

    instr_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .fetch_fault     (fetch_fault)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   rom_word = 16'h1111;
            16'd1:   rom_word = 16'h2222;
            16'd2:   rom_word = 16'h3333;
            16'd3:   rom_word = 16'h4444;
            default: rom_word = 16'hC000 | a;
        endcase
    endfunction

    // Synchronous-read ROM model.
    always @(posedge clk) rom_instruction <= rom_word(rom_address);

    always @(posedge clk) begin
        if (reset) hs_count <= 0;
        else if (instr_valid && instr_ready) hs_count <= hs_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_head(input string name, input logic v, input logic [15:0] ins, input logic [15:0] pc);
        check({name, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        if (v) begin
            check({name, ".instr"}, {16'd0, instr_out}, {16'd0, ins});
            check({name, ".pc"}, {16'd0, instr_pc}, {16'd0, pc});
        end
    endtask

    task automatic set_in(input logic rdy, input logic hlt, input logic rv, input logic [15:0] rpc);
        instr_ready    = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming from reset, then 5 cycles of back-pressure, then release.
        vec[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000};
        vec[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000};
        vec[2]  = '{1'b1, 1'b1, 16'h1111, 16'h0000};
        vec[3]  = '{1'b1, 1'b1, 16'h2222, 16'h0001};
        vec[4]  = '{1'b0, 1'b1, 16'h3333, 16'h0002};
        vec[5]  = '{1'b0, 1'b1, 16'h3333, 16'h0002};
        vec[6]  = '{1'b0, 1'b1, 16'h3333, 16'h0002};
        vec[7]  = '{1'b0, 1'b1, 16'h3333, 16'h0002};
        vec[8]  = '{1'b0, 1'b1, 16'h3333, 16'h0002};
        vec[9]  = '{1'b1, 1'b1, 16'h3333, 16'h0002};
        vec[10] = '{1'b1, 1'b1, 16'h4444, 16'h0003};
        vec[11] = '{1'b1, 1'b1, 16'hC004, 16'h0004};
        vec[12] = '{1'b1, 1'b1, 16'hC005, 16'h0005};
        vec[13] = '{1'b1, 1'b1, 16'hC006, 16'h0006};

        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid", {31'd0, instr_valid}, 32'd0);
        check("reset.instr", {16'd0, instr_out}, 32'd0);
        check("reset.pc", {16'd0, instr_pc}, 32'd0);
        check("reset.fault", {31'd0, fetch_fault}, 32'd0);
        check("reset.rom_address", {16'd0, rom_address}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            instr_ready = vec[i].ready;
            check($sformatf("stream[%0d].valid", i), {31'd0, instr_valid}, {31'd0, vec[i].exp_valid});
            check($sformatf("stream[%0d].instr", i), {16'd0, instr_out}, {16'd0, vec[i].exp_instr});
            check($sformatf("stream[%0d].pc", i), {16'd0, instr_pc}, {16'd0, vec[i].exp_pc});
            step();
        end

        // Redirect to 0x100 while one word is queued and another is in flight.
        set_in(1'b0, 1'b0, 1'b1, 16'h0100);
        exp_head("redir.n", 1'b1, 16'hC007, 16'h0007);
        step();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        exp_head("redir.n1", 1'b0, 16'h0000, 16'h0000);
        check("redir.rom_address", {16'd0, rom_address}, 32'h0100);
        step();
        exp_head("redir.n2", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("redir.n3", 1'b1, 16'hC100, 16'h0100);
        step();

        // Redirect together with an accepted handshake.
        set_in(1'b1, 1'b0, 1'b1, 16'h0200);
        exp_head("redir_pop.n", 1'b1, 16'hC101, 16'h0101);
        step();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        exp_head("redir_pop.n1", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("redir_pop.n2", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("redir_pop.n3", 1'b1, 16'hC200, 16'h0200);
        step();

        // Redirect to the last legal address, then the fault.
        set_in(1'b1, 1'b0, 1'b1, 16'd15000);
        exp_head("fault.n", 1'b1, 16'hC201, 16'h0201);
        step();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        exp_head("fault.n1", 1'b0, 16'h0000, 16'h0000);
        check("fault.n1.flag", {31'd0, fetch_fault}, 32'd0);
        step();
        check("fault.n2.flag", {31'd0, fetch_fault}, 32'd0);
        step();
        exp_head("fault.n3", 1'b1, 16'hFA98, 16'd15000);
        check("fault.n3.flag", {31'd0, fetch_fault}, 32'd1);
        step();
        exp_head("fault.n4", 1'b0, 16'h0000, 16'h0000);
        check("fault.n4.flag", {31'd0, fetch_fault}, 32'd1);
        check("fault.n4.rom_address", {16'd0, rom_address}, 32'd15001);
        step();
        set_in(1'b1, 1'b0, 1'b1, 16'h0000);
        check("fault.n5.flag", {31'd0, fetch_fault}, 32'd1);
        step();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        check("fault_clear.flag", {31'd0, fetch_fault}, 32'd0);
        exp_head("restart.n1", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("restart.n2", 1'b0, 16'h0000, 16'h0000);
        step();

        // Halt for 4 cycles: queue drains, fetch resumes at PC 2.
        set_in(1'b1, 1'b1, 1'b0, 16'h0000);
        exp_head("halt.h0", 1'b1, 16'h1111, 16'h0000);
        step();
        exp_head("halt.h1", 1'b1, 16'h2222, 16'h0001);
        step();
        exp_head("halt.h2", 1'b0, 16'h0000, 16'h0000);
        check("halt.rom_address", {16'd0, rom_address}, 32'd2);
        step();
        exp_head("halt.h3", 1'b0, 16'h0000, 16'h0000);
        step();
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        exp_head("resume.r0", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("resume.r1", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("resume.r2", 1'b1, 16'h3333, 16'h0002);
        step();
        exp_head("resume.r3", 1'b1, 16'h4444, 16'h0003);
        step();

        // Fill the queue, then reset while full.
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_head("fill.f0", 1'b1, 16'hC004, 16'h0004);
        step();
        reset = 1'b1;
        exp_head("fill.f1", 1'b1, 16'hC004, 16'h0004);
        step();
        reset = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        check("midreset.valid", {31'd0, instr_valid}, 32'd0);
        check("midreset.instr", {16'd0, instr_out}, 32'd0);
        check("midreset.pc", {16'd0, instr_pc}, 32'd0);
        check("midreset.rom_address", {16'd0, rom_address}, 32'd0);
        step();
        exp_head("refetch.n1", 1'b0, 16'h0000, 16'h0000);
        step();
        exp_head("refetch.n2", 1'b1, 16'h1111, 16'h0000);
        step();
        exp_head("refetch.n3", 1'b1, 16'h2222, 16'h0001);
        step();

`ifdef FETCH_COUNT_EN
        check("fetch_count", fetch_count, hs_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
